// File: rtl/mem_inst_prog_if.sv
// Loader and fetch signals of the instruction memory, grouped with
// master (CPU/loader side) and slave (memory side) views.
interface mem_inst_prog_if #(
    parameter int LARGURA = 32,
    parameter int IW      = 8
);
    // Loader handshake: a word moves on a rising edge where carga_valido
    // and carga_pronto are both 1; carga_ultimo is meaningful only then.
    logic [31:0]        endereco;
    logic [LARGURA-1:0] saida;
    logic               carga_inicio;
    logic               carga_valido;
    logic [LARGURA-1:0] carga_dado;
    logic               carga_ultimo;
    logic               carga_pronto;
    logic               pronto;
    logic               erro;
    logic [IW:0]        palavras;

    modport master (
        output endereco, carga_inicio, carga_valido, carga_dado, carga_ultimo,
        input  saida, carga_pronto, pronto, erro, palavras
    );

    modport slave (
        input  endereco, carga_inicio, carga_valido, carga_dado, carga_ultimo,
        output saida, carga_pronto, pronto, erro, palavras
    );
endinterface

// File: rtl/mem_inst_prog.sv
// Loadable instruction memory: a streamed program is written from index 0,
// and fetches return the stored word only once the whole program is in.
module mem_inst_prog #(
    parameter int                 LARGURA      = 32,
    parameter int                 PROFUNDIDADE = 256,
    parameter logic [LARGURA-1:0] INSTR_FORA   = LARGURA'(32'h0800_0000)
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_inst_prog_if.slave        bus,
    output logic [1:0]            o_estado
);
    localparam int IW = $clog2(PROFUNDIDADE);
    localparam int AW = (IW > 0) ? IW : 1;
    localparam logic [IW:0] PROF_C = (IW + 1)'(PROFUNDIDADE);

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        CARREGANDO = 2'd1,
        PRONTO     = 2'd2
    } estado_t;

    estado_t            r_estado;
    logic               r_carga_pronto;
    logic               r_pronto;
    logic               r_erro;
    logic [IW:0]        r_palavras;
    logic [LARGURA-1:0] r_mem [PROFUNDIDADE];

    logic               w_transfer;
    logic               w_cabe;
    logic               w_escrita;
    logic               w_dentro;
    logic [AW-1:0]      w_idx_esc;
    logic [AW-1:0]      w_idx_lei;

    // carga_inicio wins over a word offered in the same cycle.
    assign w_transfer = bus.carga_valido && r_carga_pronto && !bus.carga_inicio;
    assign w_cabe     = (r_palavras < PROF_C);
    assign w_escrita  = w_transfer && w_cabe;
    assign w_idx_esc  = AW'(r_palavras);
    assign w_idx_lei  = bus.endereco[AW-1:0];

    // palavras never exceeds the depth, so this also rejects high address bits.
    assign w_dentro   = (bus.endereco < 32'(r_palavras));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado       <= OCIOSO;
            r_carga_pronto <= 1'b0;
            r_pronto       <= 1'b0;
            r_erro         <= 1'b0;
            r_palavras     <= '0;
        end else if (bus.carga_inicio) begin
            r_estado       <= CARREGANDO;
            r_carga_pronto <= 1'b1;
            r_pronto       <= 1'b0;
            r_erro         <= 1'b0;
            r_palavras     <= '0;
        end else begin
            case (r_estado)
                CARREGANDO: begin
                    if (w_transfer) begin
                        if (w_cabe) begin
                            r_palavras <= r_palavras + 1'b1;
                        end else begin
                            r_erro <= 1'b1;
                        end
                        if (bus.carga_ultimo) begin
                            r_estado       <= PRONTO;
                            r_carga_pronto <= 1'b0;
                            r_pronto       <= 1'b1;
                        end
                    end
                end
                OCIOSO, PRONTO: begin
                    r_estado <= r_estado;
                end
                default: begin
                    r_estado       <= OCIOSO;
                    r_carga_pronto <= 1'b0;
                    r_pronto       <= 1'b0;
                end
            endcase
        end
    end

    // Array is deliberately outside reset; stale contents stay hidden behind palavras.
    always_ff @(posedge clock) begin
        if (w_escrita) begin
            r_mem[w_idx_esc] <= bus.carga_dado;
        end
    end

    always_comb begin
        bus.saida = INSTR_FORA;
        if (r_pronto && w_dentro) begin
            bus.saida = r_mem[w_idx_lei];
        end
    end

    assign bus.carga_pronto = r_carga_pronto;
    assign bus.pronto       = r_pronto;
    assign bus.erro         = r_erro;
    assign bus.palavras     = r_palavras;
    assign o_estado         = r_estado;
endmodule

// File: tb/tb_mem_inst_prog.sv
// Directed bench for mem_inst_prog: a 256-deep instance for load/fetch/reload
// behaviour and a 4-deep instance for overflow.
module tb_mem_inst_prog;
    localparam logic [31:0] HLT = 32'h0800_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    logic [1:0] estado_g;
    logic [1:0] estado_p;

    mem_inst_prog_if #(.LARGURA(32), .IW(8)) bg ();
    mem_inst_prog_if #(.LARGURA(32), .IW(2)) bp ();

    mem_inst_prog #(.LARGURA(32), .PROFUNDIDADE(256)) dut_g (
        .clock(clk), .reset(rst), .bus(bg.slave), .o_estado(estado_g)
    );
    mem_inst_prog #(.LARGURA(32), .PROFUNDIDADE(4)) dut_p (
        .clock(clk), .reset(rst), .bus(bp.slave), .o_estado(estado_p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inicio(input bit sm);
        if (sm) bp.carga_inicio = 1'b1; else bg.carga_inicio = 1'b1;
        tick();
        bp.carga_inicio = 1'b0;
        bg.carga_inicio = 1'b0;
    endtask

    task automatic palavra(input bit sm, input logic [31:0] d, input logic ult);
        if (sm) begin
            bp.carga_valido = 1'b1; bp.carga_dado = d; bp.carga_ultimo = ult;
        end else begin
            bg.carga_valido = 1'b1; bg.carga_dado = d; bg.carga_ultimo = ult;
        end
        tick();
        bp.carga_valido = 1'b0; bp.carga_ultimo = 1'b0;
        bg.carga_valido = 1'b0; bg.carga_ultimo = 1'b0;
    endtask

    task automatic ler_g(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bg.endereco = a;
        #1;
        chk(tag, bg.saida, exp);
    endtask

    task automatic ler_p(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bp.endereco = a;
        #1;
        chk(tag, bp.saida, exp);
    endtask

    initial begin
        bg.endereco = '0; bg.carga_inicio = 0; bg.carga_valido = 0; bg.carga_dado = '0; bg.carga_ultimo = 0;
        bp.endereco = '0; bp.carga_inicio = 0; bp.carga_valido = 0; bp.carga_dado = '0; bp.carga_ultimo = 0;

        // Reset state
        #2;
        chk("rst_estado", estado_g, 2'd0);
        chk("rst_carga_pronto", bg.carga_pronto, 1'b0);
        chk("rst_pronto", bg.pronto, 1'b0);
        chk("rst_erro", bg.erro, 1'b0);
        chk("rst_palavras", bg.palavras, 9'd0);
        ler_g("rst_saida", 32'd0, HLT);
        tick();
        rst = 1'b0;
        tick();

        // Word offered while idle is ignored
        palavra(0, 32'hDEAD_BEEF, 1'b0);
        chk("ocioso_palavras", bg.palavras, 9'd0);
        chk("ocioso_estado", estado_g, 2'd0);

        // Normal load with a 3-cycle gap after the first word
        inicio(0);
        chk("ini_estado", estado_g, 2'd1);
        chk("ini_carga_pronto", bg.carga_pronto, 1'b1);
        chk("ini_pronto", bg.pronto, 1'b0);
        palavra(0, 32'h9040_0005, 1'b0);
        tick(); tick(); tick();
        chk("gap_palavras", bg.palavras, 9'd1);
        chk("gap_pronto", bg.pronto, 1'b0);
        ler_g("gap_saida_oculta", 32'd0, HLT);
        palavra(0, 32'h7084_000A, 1'b0);
        palavra(0, 32'h6084_000A, 1'b0);
        palavra(0, 32'h0800_0000, 1'b1);
        chk("load_pronto", bg.pronto, 1'b1);
        chk("load_palavras", bg.palavras, 9'd4);
        chk("load_estado", estado_g, 2'd2);
        chk("load_carga_pronto", bg.carga_pronto, 1'b0);
        chk("load_erro", bg.erro, 1'b0);
        ler_g("load_end0", 32'd0, 32'h9040_0005);
        ler_g("load_end1", 32'd1, 32'h7084_000A);
        ler_g("load_end2", 32'd2, 32'h6084_000A);
        ler_g("load_end3", 32'd3, 32'h0800_0000);
        ler_g("load_end4", 32'd4, HLT);

        // Word offered while PRONTO is ignored
        palavra(0, 32'h1234_5678, 1'b0);
        chk("pronto_ign_palavras", bg.palavras, 9'd4);
        ler_g("pronto_ign_end4", 32'd4, HLT);
        ler_g("pronto_ign_end0", 32'd0, 32'h9040_0005);
        ler_g("end_alto", 32'h0001_0000, HLT);
        ler_g("end_alto1", 32'h0001_0001, HLT);
        ler_g("end_fora_prof", 32'd256, HLT);

        // Reload: start pulse with a simultaneous word drops that word
        bg.carga_valido = 1'b1; bg.carga_dado = 32'hAAAA_AAAA;
        inicio(0);
        bg.carga_valido = 1'b0;
        chk("prio_pronto", bg.pronto, 1'b0);
        chk("prio_palavras", bg.palavras, 9'd0);
        chk("prio_estado", estado_g, 2'd1);
        ler_g("prio_saida", 32'd0, HLT);
        palavra(0, 32'h1111_1111, 1'b0);
        palavra(0, 32'h2222_2222, 1'b1);
        chk("reload_palavras", bg.palavras, 9'd2);
        chk("reload_pronto", bg.pronto, 1'b1);
        ler_g("reload_end0", 32'd0, 32'h1111_1111);
        ler_g("reload_end1", 32'd1, 32'h2222_2222);
        ler_g("reload_end2", 32'd2, HLT);

        // Reset in the middle of a 5-word load
        inicio(0);
        palavra(0, 32'h3333_3333, 1'b0);
        palavra(0, 32'h4444_4444, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstmid_pronto", bg.pronto, 1'b0);
        chk("rstmid_palavras", bg.palavras, 9'd0);
        chk("rstmid_estado", estado_g, 2'd0);
        chk("rstmid_carga_pronto", bg.carga_pronto, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ler_g($sformatf("rstmid_end%0d", i), 32'(i), HLT);
        end
        tick();

        // Overflow on the 4-deep instance
        inicio(1);
        palavra(1, 32'hA000_0001, 1'b0);
        palavra(1, 32'hA000_0002, 1'b0);
        palavra(1, 32'hA000_0003, 1'b0);
        palavra(1, 32'hA000_0004, 1'b0);
        chk("ovf_cheio_palavras", bp.palavras, 3'd4);
        chk("ovf_cheio_erro", bp.erro, 1'b0);
        palavra(1, 32'hA000_0005, 1'b0);
        chk("ovf5_erro", bp.erro, 1'b1);
        chk("ovf5_palavras", bp.palavras, 3'd4);
        chk("ovf5_estado", estado_p, 2'd1);
        palavra(1, 32'hA000_0006, 1'b1);
        chk("ovf6_pronto", bp.pronto, 1'b1);
        chk("ovf6_erro", bp.erro, 1'b1);
        chk("ovf6_palavras", bp.palavras, 3'd4);
        ler_p("ovf_end0", 32'd0, 32'hA000_0001);
        ler_p("ovf_end3", 32'd3, 32'hA000_0004);
        ler_p("ovf_end4", 32'd4, HLT);
        ler_p("ovf_end5", 32'd5, HLT);
        tick();
        chk("ovf_erro_sticky", bp.erro, 1'b1);
        inicio(1);
        chk("ovf_ini_erro", bp.erro, 1'b0);
        chk("ovf_ini_pronto", bp.pronto, 1'b0);
        chk("ovf_ini_palavras", bp.palavras, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
